cpc_ram_cfg_port: RTL and testbench

//  Upstream config stage of the 512K RAM expansion CPLD. Qualifies Z80 IO writes to 0x7Fxx/0x7Exx
//  (data 0b11cccbbb), holds the bank register, and latches the DIP config bits from ramadrhi[4:3]
//  at power-up. Its outputs drive the RAM-mapping decode directly; it also gates ramadrhi drive

---
 rtl/cpc_ram_cfg_port.sv | 167 ++++++++++++++++
 tb/tb_cpc_ram_cfg_port.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpc_ram_cfg_port.sv
// cpc_ram_cfg_port
// Upstream configuration stage of the 512K RAM expansion CPLD. Qualifies Z80
// IO writes to 0x7Fxx/0x7Exx carrying data 0b11cccbbb, holds the bank
// register, and latches the DIP configuration bits from ramadrhi[4:3] once
// after reset. ramadrhi drive is held off until those pins have been sampled.
//
// Ports
//   clk        CPC 4 MHz clock, all state on posedge
//   reset_b    asynchronous active-low reset
//   iorq_b     Z80 IORQ (active low)
//   wr_b       Z80 WR (active low)
//   m1_b       Z80 M1 (active low; low with IORQ is an int-ack)
//   adr15      address bit 15 (0 = gate-array/RAM port range)
//   adr8       address bit 8 (1 = 0x7Fxx, 0 = 0x7Exx)
//   data       Z80 data bus
//   dip_pin    ramadrhi[4:3] pin inputs, read as DIP switches while undriven
//   shadow_en  static shadow-mode enable
//   ramblock   {ccc,bbb} bank/scheme register, shadow-aliased
//   mode3      bbb == 3'b011 at the last capture
//   cardsel    last capture addressed this card's port
//   dip_lat    {shadow bank hi, low512kb (0x7Exx) mode}, latched after reset
//   adrhi_oe   ramadrhi outputs may be driven
//   cfg_wr     one-cycle pulse in the cycle after the register updates
//
// Sequencer states
//   S_RST_HOLD | waiting for synchronised reset release + stretch, outputs undriven
//   S_RUN      | DIP bits latched, ramadrhi drive enabled, capture FSM active
// Capture states
//   C_IDLE     | no qualified write in progress
//   C_FILT     | qualified write seen, counting consecutive samples
//   C_CAPT     | register update cycle
//   C_WAIT     | update done, waiting for IORQ to go high

module cpc_ram_cfg_port #(
  parameter int RST_STRETCH = 2,
  parameter int FILT_LEN    = 2
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       iorq_b,
  input  logic       wr_b,
  input  logic       m1_b,
  input  logic       adr15,
  input  logic       adr8,
  input  logic [7:0] data,
  input  logic [1:0] dip_pin,
  input  logic       shadow_en,
  output logic [5:0] ramblock,
  output logic       mode3,
  output logic       cardsel,
  output logic [1:0] dip_lat,
  output logic       adrhi_oe,
  output logic       cfg_wr
);

  typedef enum logic {S_RST_HOLD, S_RUN} seq_t;
  typedef enum logic [1:0] {C_IDLE, C_FILT, C_CAPT, C_WAIT} cap_t;

  seq_t       seq_state, seq_next;
  cap_t       cap_state, cap_next;
  logic       rs_meta, rs_q;
  logic [7:0] cnt, cnt_next;
  logic [2:0] fcnt, fcnt_next, fcnt_inc;
  logic [5:0] ramblock_next;
  logic       mode3_next, cardsel_next, adrhi_oe_next, cfg_wr_next;
  logic [1:0] dip_lat_next;
  logic       q;
  logic       alias_hit;

  // Release of reset is synchronised; assertion clears everything at once.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rs_meta <= 1'b0;
      rs_q    <= 1'b0;
    end else begin
      rs_meta <= 1'b1;
      rs_q    <= rs_meta;
    end
  end

  assign q         = !iorq_b && !wr_b && m1_b && !adr15 && data[7] && data[6];
  assign fcnt_inc  = fcnt + 3'd1;
  // ccc equal to the shadow bank selected by DIP aliases down by clearing ccc[0].
  assign alias_hit = shadow_en && (data[5:3] == {dip_lat[1], 2'b11});

  always_comb begin
    seq_next      = seq_state;
    cap_next      = cap_state;
    cnt_next      = cnt;
    fcnt_next     = fcnt;
    dip_lat_next  = dip_lat;
    adrhi_oe_next = adrhi_oe;
    ramblock_next = ramblock;
    mode3_next    = mode3;
    cardsel_next  = cardsel;
    cfg_wr_next   = 1'b0;
    case (seq_state)
      S_RST_HOLD: begin
        if (rs_q) begin
          cnt_next = cnt + 8'd1;
          if (cnt == 8'(RST_STRETCH - 1)) begin
            seq_next      = S_RUN;
            dip_lat_next  = dip_pin;
            adrhi_oe_next = 1'b1;
          end
        end
      end
      S_RUN: begin
        case (cap_state)
          C_IDLE: begin
            if (q) begin
              fcnt_next = 3'd1;
              cap_next  = (FILT_LEN == 1) ? C_CAPT : C_FILT;
            end
          end
          C_FILT: begin
            if (!q) begin
              cap_next = C_IDLE;
            end else begin
              fcnt_next = fcnt_inc;
              if (fcnt_inc == 3'(FILT_LEN)) cap_next = C_CAPT;
            end
          end
          C_CAPT: begin
            ramblock_next = alias_hit ? {data[5:4], 1'b0, data[2:0]} : data[5:0];
            mode3_next    = (data[2:0] == 3'b011);
            cardsel_next  = dip_lat[0] ? !adr8 : adr8;
            cfg_wr_next   = 1'b1;
            cap_next      = C_WAIT;
          end
          C_WAIT: begin
            if (iorq_b) cap_next = C_IDLE;
          end
          default: cap_next = C_IDLE;
        endcase
      end
      default: seq_next = S_RST_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      seq_state <= S_RST_HOLD;
      cap_state <= C_IDLE;
      cnt       <= 8'd0;
      fcnt      <= 3'd0;
      dip_lat   <= 2'b00;
      adrhi_oe  <= 1'b0;
      ramblock  <= 6'd0;
      mode3     <= 1'b0;
      cardsel   <= 1'b0;
      cfg_wr    <= 1'b0;
    end else begin
      seq_state <= seq_next;
      cap_state <= cap_next;
      cnt       <= cnt_next;
      fcnt      <= fcnt_next;
      dip_lat   <= dip_lat_next;
      adrhi_oe  <= adrhi_oe_next;
      ramblock  <= ramblock_next;
      mode3     <= mode3_next;
      cardsel   <= cardsel_next;
      cfg_wr    <= cfg_wr_next;
    end
  end

endmodule

// File: tb/tb_cpc_ram_cfg_port.sv
// Bench for cpc_ram_cfg_port: directed scenarios plus randomized IO traffic,
// every cycle compared against an event-history reference model.
module tb_cpc_ram_cfg_port;
  localparam int RST_STRETCH = 2;
  localparam int FILT_LEN    = 2;
  localparam int RUN_EDGE    = 2 + RST_STRETCH;

  logic       clk = 1'b0;
  logic       reset_b = 1'b0;
  logic       iorq_b = 1'b1, wr_b = 1'b1, m1_b = 1'b1, adr15 = 1'b1, adr8 = 1'b0;
  logic [7:0] data = 8'h00;
  logic [1:0] dip_pin = 2'b00;
  logic       shadow_en = 1'b0;
  logic [5:0] ramblock;
  logic       mode3, cardsel, adrhi_oe, cfg_wr;
  logic [1:0] dip_lat;

  cpc_ram_cfg_port #(.RST_STRETCH(RST_STRETCH), .FILT_LEN(FILT_LEN)) dut (
    .clk(clk), .reset_b(reset_b), .iorq_b(iorq_b), .wr_b(wr_b), .m1_b(m1_b),
    .adr15(adr15), .adr8(adr8), .data(data), .dip_pin(dip_pin), .shadow_en(shadow_en),
    .ramblock(ramblock), .mode3(mode3), .cardsel(cardsel), .dip_lat(dip_lat),
    .adrhi_oe(adrhi_oe), .cfg_wr(cfg_wr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: keeps the history of qualifier and IORQ samples since
  // the first RUN edge and decides captures from that history directly.
  int         rel_edges;
  bit         q_hist[$];
  bit         iohi_hist[$];
  int         last_cap;
  logic [5:0] m_ramblock;
  logic       m_mode3, m_cardsel, m_oe, m_cfg_wr;
  logic [1:0] m_dip;
  int         pulses;
  int         first_pulse;

  function automatic logic [11:0] dut_outs();
    return {ramblock, mode3, cardsel, dip_lat, adrhi_oe, cfg_wr};
  endfunction

  function automatic logic [11:0] model_outs();
    return {m_ramblock, m_mode3, m_cardsel, m_dip, m_oe, m_cfg_wr};
  endfunction

  task automatic model_clear();
    rel_edges = 0;
    q_hist.delete();
    iohi_hist.delete();
    last_cap = -1;
    m_ramblock = 6'd0; m_mode3 = 1'b0; m_cardsel = 1'b0;
    m_oe = 1'b0; m_cfg_wr = 1'b0; m_dip = 2'b00;
  endtask

  task automatic model_edge();
    bit q, cap, released;
    int k, s;
    m_cfg_wr = 1'b0;
    rel_edges++;
    if (rel_edges == RUN_EDGE) begin
      m_dip = dip_pin;
      m_oe  = 1'b1;
    end else if (rel_edges > RUN_EDGE) begin
      q = !iorq_b && !wr_b && m1_b && !adr15 && data[7] && data[6];
      k = q_hist.size();
      q_hist.push_back(q);
      iohi_hist.push_back(iorq_b);
      // capture at k needs FILT_LEN qualified samples just before k, starting
      // from an idle point: previous sample unqualified and any earlier
      // capture released by an IORQ-high sample.
      cap = (k >= FILT_LEN);
      if (cap) for (int j = k - FILT_LEN; j < k; j++) if (!q_hist[j]) cap = 0;
      s = k - FILT_LEN - 1;
      if (cap && last_cap > s) cap = 0;
      if (cap && s >= 0) begin
        if (q_hist[s]) cap = 0;
        if (last_cap >= 0) begin
          released = 0;
          for (int j = last_cap + 1; j <= s; j++) if (iohi_hist[j]) released = 1;
          if (!released) cap = 0;
        end
      end
      if (cap) begin
        last_cap = k;
        m_cfg_wr = 1'b1;
        if (shadow_en && data[5:3] == {m_dip[1], 2'b11})
          m_ramblock = {data[5:4], 1'b0, data[2:0]};
        else
          m_ramblock = data[5:0];
        m_mode3   = (data[2:0] == 3'b011);
        m_cardsel = m_dip[0] ? !adr8 : adr8;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (reset_b) model_edge();
    check_val("outs", {20'd0, dut_outs()}, {20'd0, model_outs()});
    if (cfg_wr) pulses++;
  endtask

  task automatic do_reset(input logic [1:0] dp, input int hold);
    reset_b = 1'b0;
    #1;
    model_clear();
    check_val("rst_async", {20'd0, dut_outs()}, 32'd0);
    dip_pin = dp;
    repeat (hold) cyc();
    reset_b = 1'b1;
  endtask

  task automatic io_op(input bit a8, input logic [7:0] d, input int hold, input int gap,
                       input bit m1v, input bit a15);
    int i;
    pulses = 0;
    first_pulse = 0;
    adr15 = a15; adr8 = a8; data = d; m1_b = m1v;
    iorq_b = 1'b0; wr_b = 1'b0;
    i = 0;
    repeat (hold) begin
      cyc(); i++;
      if (cfg_wr && first_pulse == 0) first_pulse = i;
    end
    iorq_b = 1'b1; wr_b = 1'b1; m1_b = 1'b1;
    repeat (gap) begin
      cyc(); i++;
      if (cfg_wr && first_pulse == 0) first_pulse = i;
    end
  endtask

  task automatic wait_run(input logic [1:0] dp);
    int n;
    do_reset(dp, 2);
    n = 0;
    while (!adrhi_oe && n < 20) begin
      cyc(); n++;
    end
    check_val("oe_delay", n, RUN_EDGE);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int kind;
    model_clear();
    #2;
    // 1: power-up sequencing and DIP latch
    check_val("rst_state", {20'd0, dut_outs()}, 32'd0);
    wait_run(2'b10);
    check_val("dip_lat_10", dip_lat, 2'b10);
    cyc();
    check_val("oe_held", adrhi_oe, 1'b1);

    // 2: basic capture, latency and single pulse
    wait_run(2'b00);
    io_op(1'b1, 8'hC2, 4, 2, 1'b1, 1'b0);
    check_val("t2_ramblock", ramblock, 6'h02);
    check_val("t2_cardsel", cardsel, 1'b1);
    check_val("t2_mode3", mode3, 1'b0);
    check_val("t2_pulses", pulses, 1);
    check_val("t2_latency", first_pulse, FILT_LEN + 1);

    // 3: mode3 and port/card selection
    io_op(1'b1, 8'hCB, 3, 2, 1'b1, 1'b0);
    check_val("t3_mode3", mode3, 1'b1);
    check_val("t3_ramblock", ramblock, 6'h0B);
    check_val("t3_cardsel7f", cardsel, 1'b1);
    io_op(1'b0, 8'hCB, 3, 2, 1'b1, 1'b0);
    check_val("t3_cardsel7e_dip0", cardsel, 1'b0);
    wait_run(2'b01);
    io_op(1'b0, 8'hCB, 3, 2, 1'b1, 1'b0);
    check_val("t3_cardsel7e_dip1", cardsel, 1'b1);
    check_val("t3_mode3_dip1", mode3, 1'b1);
    check_val("t3_ramblock_dip1", ramblock, 6'h0B);

    // 4: shadow aliasing
    shadow_en = 1'b1;
    wait_run(2'b10);
    io_op(1'b1, 8'hFC, 3, 2, 1'b1, 1'b0);
    check_val("t4_alias_hi", ramblock, 6'b110100);
    wait_run(2'b00);
    io_op(1'b1, 8'hDC, 3, 2, 1'b1, 1'b0);
    check_val("t4_alias_lo", ramblock, 6'b010100);
    shadow_en = 1'b0;

    // 5: rejected writes
    io_op(1'b1, 8'hC2, 3, 2, 1'b1, 1'b0);
    io_op(1'b1, 8'hC5, 1, 2, 1'b1, 1'b0);
    check_val("t5_glitch_pulses", pulses, 0);
    io_op(1'b1, 8'hC4, 4, 2, 1'b0, 1'b0);
    check_val("t5_intack_pulses", pulses, 0);
    io_op(1'b1, 8'h8C, 4, 2, 1'b1, 1'b0);
    check_val("t5_pen_pulses", pulses, 0);
    io_op(1'b1, 8'hC4, 4, 2, 1'b1, 1'b1);
    check_val("t5_adr15_pulses", pulses, 0);
    check_val("t5_ramblock", ramblock, 6'h02);

    // 6: reset while waiting after a capture, write held across release
    adr15 = 1'b0; adr8 = 1'b1; data = 8'hC7; m1_b = 1'b1; iorq_b = 1'b0; wr_b = 1'b0;
    pulses = 0;
    for (int n = 0; n < 10 && pulses == 0; n++) cyc();
    check_val("t6_captured", pulses, 1);
    cyc();
    do_reset(2'b01, 2);
    pulses = 0;
    repeat (RUN_EDGE + FILT_LEN + 3) cyc();
    check_val("t6_recapture", pulses, 1);
    check_val("t6_dip_lat", dip_lat, 2'b01);
    check_val("t6_ramblock", ramblock, 6'h07);
    check_val("t6_cardsel", cardsel, 1'b0);
    iorq_b = 1'b1; wr_b = 1'b1;
    cyc();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) do_reset(2'($urandom_range(0, 3)), $urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) shadow_en = ~shadow_en;
      kind = $urandom_range(0, 9);
      d = 8'($urandom);
      if (kind < 7) d[7:6] = 2'b11;
      if (kind < 7 && $urandom_range(0, 2) == 0) d[4:3] = 2'b11;
      io_op(1'($urandom_range(0, 1)), d, $urandom_range(1, 5), $urandom_range(0, 3),
            (kind == 8) ? 1'b0 : 1'b1, (kind == 9) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
